// File: rtl/gate_tt_checker.sv
// On-chip BIST collector for a 2-input gate: walks {A,B} through 00..11 and
// compares the sampled Y against TRUTH_TABLE, reporting a fail mask and count.
module gate_tt_checker #(
  parameter logic [3:0] TRUTH_TABLE   = 4'b0001,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] vec;
  logic [3:0] cnt;
  logic       mismatch;
  logic [3:0] mask_nxt;

  // Mask including the vector being sampled this cycle, so pass reflects vector 3 too.
  always_comb begin
    mismatch = (Y != TRUTH_TABLE[vec]);
    mask_nxt = fail_mask;
    if (mismatch) mask_nxt = fail_mask | (4'b0001 << vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= 2'd0;
      cnt       <= 4'd0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'd0;
      err_count <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          A    <= 1'b0;
          B    <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state     <= DRIVE;
            vec       <= 2'd0;
            cnt       <= 4'd0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            fail_mask <= 4'd0;
            err_count <= 3'd0;
          end
        end
        DRIVE: begin
          if (cnt == CNT_LAST) begin
            cnt <= 4'd0;
            if (mismatch) begin
              fail_mask <= mask_nxt;
              err_count <= err_count + 3'd1;
            end
            if (vec == 2'd3) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mask_nxt == 4'd0);
              A     <= 1'b0;
              B     <= 1'b0;
            end else begin
              vec      <= vec + 2'd1;
              {A, B}   <= vec + 2'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          vec   <= 2'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
